// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - handshake bundle between alu_sequencer and the register bank / ALU pair
interface alu_sequencer_if;
  logic [7:0] instr;
  logic       init;
  logic       alu_start;
  logic       alu_done;
  logic [3:0] alu_result;
  logic [3:0] data_result;
  logic       rd;
  logic       bank_done;

  modport master (
    output instr, init, alu_start, data_result, rd,
    input  alu_done, alu_result, bank_done
  );

  modport slave (
    input  instr, init, alu_start, data_result, rd,
    output alu_done, alu_result, bank_done
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - program sequencer driving the ALU register bank and ALU as initiator
module alu_sequencer #(
  parameter int PROG_DEPTH  = 16,
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [7:0]                    prog_wdata,
  alu_sequencer_if.master               bus,
  output logic [$clog2(PROG_DEPTH)-1:0] pc,
  output logic                          busy,
  output logic                          finished,
  output logic                          error
);
  localparam int PW = $clog2(PROG_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(INIT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXEC, WB, WAIT_WB, DONE} state_t;

  state_t        state, state_d;
  logic [7:0]    mem [PROG_DEPTH];
  logic [7:0]    instr_q, instr_d;
  logic [3:0]    data_q, data_d;
  logic [PW-1:0] pc_d;
  logic          error_d;
  logic [TW-1:0] wait_cnt, wait_cnt_d;
  logic [IW-1:0] issue_cnt, issue_cnt_d;
  logic          init_c, alu_start_c, rd_c, finished_c;
  logic          timed_out;

  // Program memory is deliberately outside reset so a reset keeps the loaded program.
  always_ff @(posedge clk) begin
    if (state == IDLE && prog_we)
      mem[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= '0;
      instr_q   <= '0;
      data_q    <= '0;
      error     <= 1'b0;
      wait_cnt  <= '0;
      issue_cnt <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      instr_q   <= instr_d;
      data_q    <= data_d;
      error     <= error_d;
      wait_cnt  <= wait_cnt_d;
      issue_cnt <= issue_cnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    instr_d     = instr_q;
    data_d      = data_q;
    error_d     = error;
    wait_cnt_d  = wait_cnt;
    issue_cnt_d = issue_cnt;
    init_c      = 1'b0;
    alu_start_c = 1'b0;
    rd_c        = 1'b0;
    finished_c  = 1'b0;
    timed_out   = (wait_cnt + TW'(1)) == TW'(TIMEOUT);

    case (state)
      IDLE: begin
        if (start) begin
          pc_d    = '0;
          error_d = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        instr_d     = mem[pc];
        issue_cnt_d = '0;
        state_d     = ISSUE;
      end
      ISSUE: begin
        init_c = 1'b1;
        if (issue_cnt == IW'(INIT_CYCLES - 1)) begin
          wait_cnt_d = '0;
          state_d    = EXEC;
        end else begin
          issue_cnt_d = issue_cnt + IW'(1);
        end
      end
      EXEC: begin
        // wait_cnt==0 marks the start cycle, where a stale alu_done must not count.
        alu_start_c = (wait_cnt == '0);
        if (wait_cnt != '0 && bus.alu_done) begin
          data_d  = bus.alu_result;
          state_d = WB;
        end else if (timed_out) begin
          alu_start_c = 1'b0;
          error_d     = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt + TW'(1);
        end
      end
      WB: begin
        rd_c       = 1'b1;
        wait_cnt_d = '0;
        state_d    = WAIT_WB;
      end
      WAIT_WB: begin
        if (bus.bank_done) begin
          if (instr_q[0] || pc == PW'(PROG_DEPTH - 1)) begin
            state_d = DONE;
          end else begin
            pc_d    = pc + PW'(1);
            state_d = FETCH;
          end
        end else if (timed_out) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt + TW'(1);
        end
      end
      DONE: begin
        finished_c = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.instr       = instr_q;
  assign bus.init        = init_c;
  assign bus.alu_start   = alu_start_c;
  assign bus.data_result = data_q;
  assign bus.rd          = rd_c;
  assign busy            = (state != IDLE);
  assign finished        = finished_c;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer
module tb_alu_sequencer;
  localparam int DEPTH = 16;
  localparam int TMO   = 15;

  typedef struct {
    logic [31:0] prog;
    int          n;
    logic [15:0] res;
    int          ad;
    int          bd;
    int          exp_wb;
    int          exp_cyc;
    int          exp_pc;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, start, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_wdata;
  logic [3:0] pc;
  logic       busy, finished, error;

  alu_sequencer_if bus ();

  alu_sequencer #(.PROG_DEPTH(DEPTH), .INIT_CYCLES(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .bus(bus), .pc(pc), .busy(busy), .finished(finished), .error(error)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mem_m [DEPTH];
  logic [3:0] res_a [DEPTH];
  int         ad_a [DEPTH];
  int         bd_a [DEPTH];
  logic       alu_en = 1'b1;
  int         run_id = 0;
  logic [7:0] wb_instr [$];
  logic [3:0] wb_data [$];
  int         init_runs [$];
  int         init_unstable;

  // ALU: answers alu_start after ad_a[pc] cycles; alu_result is noise except on the done cycle.
  initial begin : alu_model
    int         wait_n;
    logic [3:0] pend;
    wait_n = 0;
    pend = '0;
    bus.alu_done = 1'b0;
    bus.alu_result = '0;
    forever begin
      @(negedge clk);
      bus.alu_done = 1'b0;
      bus.alu_result = 4'($urandom);
      if (wait_n > 0) begin
        wait_n--;
        if (wait_n == 0) begin
          bus.alu_done = 1'b1;
          bus.alu_result = pend;
        end
      end
      if (bus.alu_start && alu_en) begin
        wait_n = ad_a[pc];
        pend = res_a[pc];
      end
    end
  end

  initial begin : bank_model
    int wait_n;
    wait_n = 0;
    bus.bank_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.bank_done = 1'b0;
      if (wait_n > 0) begin
        wait_n--;
        if (wait_n == 0) bus.bank_done = 1'b1;
      end
      if (bus.rd) wait_n = bd_a[pc];
    end
  end

  initial begin : monitor
    int         seen_id, irun;
    logic [7:0] first_instr;
    seen_id = 0;
    irun = 0;
    first_instr = '0;
    init_unstable = 0;
    forever begin
      @(negedge clk);
      if (run_id != seen_id) begin
        seen_id = run_id;
        wb_instr.delete();
        wb_data.delete();
        init_runs.delete();
        init_unstable = 0;
        irun = 0;
      end
      if (bus.rd) begin
        wb_instr.push_back(bus.instr);
        wb_data.push_back(bus.data_result);
      end
      if (bus.init) begin
        if (irun == 0) first_instr = bus.instr;
        else if (bus.instr !== first_instr) init_unstable++;
        irun++;
      end else if (irun > 0) begin
        init_runs.push_back(irun);
        irun = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({bus.instr, bus.init, bus.alu_start, bus.data_result, bus.rd, pc, busy, finished, error});
  endfunction

  task automatic load(input int addr, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = 4'(addr);
    prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
    mem_m[addr] = d;
  endtask

  task automatic set_resp(input int k, input logic [3:0] r, input int ad, input int bd);
    res_a[k] = r;
    ad_a[k] = ad;
    bd_a[k] = bd;
  endtask

  task automatic run_check(input string tag, input int exp_wb, input int exp_cyc,
                           input int exp_pc, input bit disturb);
    int cyc;
    bit fin;
    int bad;
    run_id++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    fin = 1'b0;
    chk({tag, " error cleared"}, 32'(error), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    while (cyc < 400) begin
      if (finished) begin
        fin = 1'b1;
        break;
      end
      if (disturb && cyc == 5) begin
        start = 1'b1;
        prog_we = 1'b1;
        prog_addr = 4'd0;
        prog_wdata = 8'hFF;
      end else begin
        start = 1'b0;
        prog_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    prog_we = 1'b0;
    chk({tag, " finished seen"}, 32'(fin), 32'd1);
    chk({tag, " cycles"}, cyc, exp_cyc);
    chk({tag, " pc at finish"}, 32'(pc), exp_pc);
    @(negedge clk);
    chk({tag, " finished pulse width"}, 32'(finished), 32'd0);
    chk({tag, " idle after"}, 32'(busy), 32'd0);
    chk({tag, " pc held"}, 32'(pc), exp_pc);
    chk({tag, " error"}, 32'(error), 32'd0);
    chk({tag, " writebacks"}, wb_instr.size(), exp_wb);
    for (int k = 0; k < exp_wb && k < wb_instr.size(); k++) begin
      chk($sformatf("%s wb%0d instr", tag, k), 32'(wb_instr[k]), 32'(mem_m[k]));
      chk($sformatf("%s wb%0d data", tag, k), 32'(wb_data[k]), 32'(res_a[k]));
    end
    bad = 0;
    foreach (init_runs[i]) if (init_runs[i] != 2) bad++;
    chk({tag, " init runs"}, init_runs.size(), exp_wb);
    chk({tag, " init width"}, bad, 0);
    chk({tag, " instr stable in init"}, init_unstable, 0);
  endtask

  initial begin : main
    vec_t tbl [4];
    int   cyc, sc;
    reset = 1'b1;
    start = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_wdata = '0;
    tbl[0] = '{prog: 32'h0000_1108, n: 2, res: 16'h00A5, ad: 1, bd: 1, exp_wb: 2, exp_cyc: 15, exp_pc: 1};
    tbl[1] = '{prog: 32'h0000_0081, n: 1, res: 16'h0007, ad: 4, bd: 1, exp_wb: 1, exp_cyc: 11, exp_pc: 0};
    tbl[2] = '{prog: 32'h0033_200C, n: 3, res: 16'h0E3C, ad: 2, bd: 3, exp_wb: 3, exp_cyc: 31, exp_pc: 2};
    tbl[3] = '{prog: 32'h00FF_0504, n: 3, res: 16'h0F09, ad: 1, bd: 2, exp_wb: 2, exp_cyc: 17, exp_pc: 1};

    repeat (3) @(negedge clk);
    chk("reset outputs", out_vec(), 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) load(k, tbl[i].prog[8*k +: 8]);
      for (int k = 0; k < DEPTH; k++) begin
        if (k < 4) set_resp(k, tbl[i].res[4*k +: 4], tbl[i].ad, tbl[i].bd);
        else set_resp(k, 4'h0, tbl[i].ad, tbl[i].bd);
      end
      run_check($sformatf("vec%0d", i), tbl[i].exp_wb, tbl[i].exp_cyc, tbl[i].exp_pc, 1'b0);
    end

    // Timeout: second instruction never gets alu_done.
    load(0, 8'h08);
    load(1, 8'h11);
    set_resp(0, 4'h3, 1, 1);
    set_resp(1, 4'h4, 1, 1);
    run_id++;
    alu_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    sc = 0;
    while (cyc < 100 && !error) begin
      if (bus.rd) alu_en = 1'b0;
      if (bus.alu_start) sc = cyc;
      @(negedge clk);
      cyc++;
    end
    chk("timeout error", 32'(error), 32'd1);
    chk("timeout latency", cyc - sc, TMO);
    chk("timeout busy", 32'(busy), 32'd0);
    chk("timeout pc held", 32'(pc), 32'd1);
    chk("timeout strobes", 32'({bus.init, bus.rd, bus.alu_start}), 32'd0);
    #1;
    chk("timeout writebacks", wb_instr.size(), 1);
    repeat (4) @(negedge clk);
    chk("error sticky", 32'(error), 32'd1);
    alu_en = 1'b1;
    run_check("after timeout", 2, 15, 1, 1'b0);

    // Reset while in WB.
    set_resp(0, 4'h5, 1, 1);
    set_resp(1, 4'hA, 1, 1);
    run_id++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 100 && !bus.rd) begin
      @(negedge clk);
      cyc++;
    end
    chk("reset test reaches WB", cyc, 6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset in WB outputs", out_vec(), 32'd0);
    @(negedge clk);
    chk("cycle after reset outputs", out_vec(), 32'd0);
    repeat (4) @(negedge clk);
    chk("stray bank_done ignored", 32'(busy), 32'd0);
    run_check("post reset", 2, 15, 1, 1'b0);

    // Sixteen non-final words: must stop at the last address without wrapping.
    for (int k = 0; k < DEPTH; k++) begin
      load(k, 8'((k * 16) | 4 | ((k % 2) * 2)));
      set_resp(k, 4'(k ^ 5), 1, 1);
    end
    run_check("sixteen", 16, 113, 15, 1'b0);
    repeat (3) @(negedge clk);
    chk("pc no wrap", 32'(pc), 32'd15);

    // prog_we and start while busy.
    load(0, 8'h08);
    load(1, 8'h11);
    set_resp(0, 4'h5, 1, 1);
    set_resp(1, 4'hA, 1, 1);
    run_check("disturbed", 2, 15, 1, 1'b1);
    run_check("mem intact", 2, 15, 1, 1'b0);

    for (int it = 0; it < 12; it++) begin
      logic [7:0] w;
      int         ew, ec;
      for (int k = 0; k < DEPTH; k++) begin
        w = 8'($urandom);
        w[0] = ($urandom_range(0, 4) == 0);
        load(k, w);
        set_resp(k, 4'($urandom), int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
      end
      ew = 0;
      ec = 1;
      for (int k = 0; k < DEPTH; k++) begin
        ew++;
        ec += 5 + ad_a[k] + bd_a[k];
        if (mem_m[k][0]) break;
      end
      run_check($sformatf("rand%0d", it), ew, ec, ew - 1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control sequencer that drives the 2-entry, 4-bit ALU register bank as its initiator.
- Holds a small program of 8-bit instructions and fetches them in order.
- Per instruction: presents the instruction to the bank with init, starts the ALU and waits for its result, then writes the result back with rd and waits for the bank's done.
- Sits between the top-level start/program-load interface and the register bank / ALU pair.

Parameters:
- PROG_DEPTH, 16, number of program words; pc width is clog2(PROG_DEPTH).
- INIT_CYCLES, 2, cycles init is held high. The bank latches the operand selects, then reads them one cycle later.
- TIMEOUT, 15, maximum wait cycles for alu_done or bank_done before an error abort.

Ports:
- clk  in  1  clock, all logic on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin execution at pc=0; sampled only in IDLE
- prog_we  in  1  program write strobe; honoured only in IDLE
- prog_addr  in  clog2(PROG_DEPTH)  program write address
- prog_wdata  in  8  program write data
- instr  out  8  current instruction to the bank
- init  out  1  bank decode/operand-read enable
- alu_start  out  1  one-cycle ALU start pulse
- alu_done  in  1  ALU result valid
- alu_result  in  4  ALU result
- data_result  out  4  write-back data to the bank
- rd  out  1  bank write strobe, one cycle
- bank_done  in  1  bank write acknowledge
- pc  out  clog2(PROG_DEPTH)  current program counter
- busy  out  1  high in every state except IDLE
- finished  out  1  one-cycle pulse at normal program end
- error  out  1  sticky timeout flag

Behaviour:
- Reset values: instr=0, init=0, alu_start=0, data_result=0, rd=0, pc=0, busy=0, finished=0, error=0, state=IDLE, timeout counter=0.
- Reset does not clear program memory.
- A reset asserted in any state returns the block to IDLE at the next edge. rd and alu_start are never asserted in the cycle after reset.
- Program memory is written synchronously when prog_we=1 in IDLE. prog_we is ignored outside IDLE.
- Instruction word: bits [7:2] are passed to the bank unmodified. bit[0]=1 marks the last instruction. bit[1] is reserved.
- IDLE: if start=1, clear pc to 0, clear error, and go to FETCH. If start and prog_we are both high, the write occurs and start is also accepted.
- FETCH (1 cycle): instr <= mem[pc]. Go to ISSUE.
- ISSUE: init=1 for exactly INIT_CYCLES cycles with instr stable. Then go to EXEC.
- EXEC, first cycle: alu_start=1. alu_done is ignored in this cycle.
- EXEC, later cycles: on alu_done=1, capture data_result <= alu_result and go to WB.
- WB (1 cycle): rd=1 and data_result stable. Go to WAIT_WB.
- WAIT_WB: on bank_done=1, leave the state:
  - go to DONE if instr[0]=1 or pc=PROG_DEPTH-1;
  - otherwise pc <= pc+1 and go to FETCH.
- DONE (1 cycle): finished=1. Go to IDLE.
- Timeout:
  - The counter clears on entry to EXEC and on entry to WAIT_WB, and increments each cycle in those states while the awaited handshake is absent.
  - When the counter reaches TIMEOUT: set error=1, drive init, rd and alu_start to 0, and go to IDLE with pc held.
  - error stays set until reset or the next accepted start.
- Minimum latency with immediate handshakes: 7 cycles per instruction, one each for FETCH, ISSUE, ISSUE, EXEC, EXEC, WB and WAIT_WB. DONE adds 1 cycle after the last instruction.
- alu_done or bank_done asserted outside their waiting states is ignored.
- start while busy=1 is ignored.

Test Plan:
1. Load mem[0]=8'h08, mem[1]=8'h11, start. ALU returns 4'h5 then 4'hA, each alu_done one cycle after alu_start; bank_done one cycle after rd.
   Required: instr=8'h08 with init high 2 cycles; rd with data_result=5; then instr=8'h11; rd with data_result=A; finished pulse; 15 cycles from start acceptance to finished.
2. Single instruction 8'h81. Delay alu_done 4 cycles after alu_start.
   Required: EXEC lasts 5 cycles; data_result latches the value present on the alu_done cycle; finished pulses; pc=0.
3. Withhold alu_done.
   Required: error=1 after TIMEOUT=15 wait cycles; busy=0; rd never asserted. A following start clears error.
4. Assert reset during WB.
   Required: next cycle all outputs are zero and state is IDLE. A subsequent start with the program unchanged runs correctly.
5. 16 words with bit[0]=0 throughout.
   Required: execution stops after pc=15; finished pulses; pc does not wrap to 0.
6. prog_we and start pulsed while busy.
   Required: memory is unchanged (verify by a later run) and execution is undisturbed.
